// File: rtl/branch_predictor_table_if.sv
// Lookup/resolve bundle for branch_predictor_table.
// The master side belongs to the pipeline (IF drives the lookup index, EX
// drives resolved branches); the slave side belongs to the predictor table.
interface branch_predictor_table_if #(
  parameter int INDEX_BITS = 3,
  parameter int STAT_BITS  = 16
);
  logic [INDEX_BITS-1:0] LOOKUP_ADDR;
  logic                  PREDICT;
  logic                  UPDATE_VALID;
  logic [INDEX_BITS-1:0] UPDATE_ADDR;
  logic                  OUTCOME;
  logic                  PREDICTION;
  logic                  MISS;
  logic [INDEX_BITS-1:0] ADDR_W;
  logic [STAT_BITS-1:0]  BRANCH_COUNT;
  logic [STAT_BITS-1:0]  MISS_COUNT;

  modport master (
    output LOOKUP_ADDR, UPDATE_VALID, UPDATE_ADDR, OUTCOME, PREDICTION,
    input  PREDICT, MISS, ADDR_W, BRANCH_COUNT, MISS_COUNT
  );

  modport slave (
    input  LOOKUP_ADDR, UPDATE_VALID, UPDATE_ADDR, OUTCOME, PREDICTION,
    output PREDICT, MISS, ADDR_W, BRANCH_COUNT, MISS_COUNT
  );
endinterface

// File: rtl/branch_predictor_table.sv
// Direct-mapped table of saturating branch counters.
// Fetch reads a prediction combinationally; execute writes back resolved
// outcomes. A registered miss flag/index pair and saturating statistics
// counters report resolution results one cycle later.
module branch_predictor_table #(
  parameter int INDEX_BITS = 3,
  parameter int CTR_BITS   = 2,
  parameter int STAT_BITS  = 16
) (
  input  logic                      CLOCK,
  input  logic                      INIT,
  branch_predictor_table_if.slave   bus
);

  localparam int DEPTH       = 1 << INDEX_BITS;
  // Weakly-not-taken: MSB clear, all lower bits set (0 for a 1-bit counter).
  localparam int CTR_WNT_INT = (1 << (CTR_BITS - 1)) - 1;
  localparam logic [CTR_BITS-1:0]  CTR_WNT   = CTR_WNT_INT[CTR_BITS-1:0];
  localparam logic [CTR_BITS-1:0]  CTR_MAX   = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]  CTR_ZERO  = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0]  CTR_ONE   = CTR_BITS'(1'b1);
  localparam logic [STAT_BITS-1:0] STAT_MAX  = {STAT_BITS{1'b1}};
  localparam logic [STAT_BITS-1:0] STAT_ZERO = {STAT_BITS{1'b0}};
  localparam logic [STAT_BITS-1:0] STAT_ONE  = STAT_BITS'(1'b1);
  localparam logic [INDEX_BITS-1:0] IDX_ZERO = {INDEX_BITS{1'b0}};

  // Move a counter one step toward the resolved direction, clamping at both ends.
  function automatic logic [CTR_BITS-1:0] ctr_step(
    input logic [CTR_BITS-1:0] cur,
    input logic                taken
  );
    logic [CTR_BITS-1:0] nxt;
    if (taken) begin
      if (cur == CTR_MAX) nxt = cur;
      else                nxt = cur + CTR_ONE;
    end else begin
      if (cur == CTR_ZERO) nxt = cur;
      else                 nxt = cur - CTR_ONE;
    end
    return nxt;
  endfunction

  // Statistics increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_BITS-1:0] stat_inc(input logic [STAT_BITS-1:0] cur);
    logic [STAT_BITS-1:0] nxt;
    if (cur == STAT_MAX) nxt = cur;
    else                 nxt = cur + STAT_ONE;
    return nxt;
  endfunction

  logic [CTR_BITS-1:0]   table_r [DEPTH];
  logic                  miss_r;
  logic [INDEX_BITS-1:0] addr_w_r;
  logic [STAT_BITS-1:0]  branch_count_r;
  logic [STAT_BITS-1:0]  miss_count_r;

  logic                  mispredict_s;
  logic [CTR_BITS-1:0]   entry_next_s;
  logic [STAT_BITS-1:0]  branch_count_next_s;
  logic [STAT_BITS-1:0]  miss_count_next_s;

  // Next-state values for the entry being resolved and for the statistics.
  always_comb begin
    mispredict_s        = bus.OUTCOME ^ bus.PREDICTION;
    entry_next_s        = ctr_step(table_r[bus.UPDATE_ADDR], bus.OUTCOME);
    branch_count_next_s = branch_count_r;
    miss_count_next_s   = miss_count_r;
    if (bus.UPDATE_VALID) begin
      branch_count_next_s = stat_inc(branch_count_r);
      if (mispredict_s) begin
        miss_count_next_s = stat_inc(miss_count_r);
      end else begin
        miss_count_next_s = miss_count_r;
      end
    end else begin
      branch_count_next_s = branch_count_r;
      miss_count_next_s   = miss_count_r;
    end
  end

  // Counter table: INIT reloads every entry, a resolved branch trains one entry.
  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= CTR_WNT;
      end
    end else if (bus.UPDATE_VALID) begin
      table_r[bus.UPDATE_ADDR] <= entry_next_s;
    end
  end

  // Miss flag pulses for one cycle per resolution; index holds until the next one.
  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      miss_r   <= 1'b0;
      addr_w_r <= IDX_ZERO;
    end else if (bus.UPDATE_VALID) begin
      miss_r   <= mispredict_s;
      addr_w_r <= bus.UPDATE_ADDR;
    end else begin
      miss_r   <= 1'b0;
      addr_w_r <= addr_w_r;
    end
  end

  // Branch and misprediction totals since the last INIT.
  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      branch_count_r <= STAT_ZERO;
      miss_count_r   <= STAT_ZERO;
    end else begin
      branch_count_r <= branch_count_next_s;
      miss_count_r   <= miss_count_next_s;
    end
  end

  // Lookup is read straight from the table: no bypass of a same-cycle update.
  assign bus.PREDICT      = table_r[bus.LOOKUP_ADDR][CTR_BITS-1];
  assign bus.MISS         = miss_r;
  assign bus.ADDR_W       = addr_w_r;
  assign bus.BRANCH_COUNT = branch_count_r;
  assign bus.MISS_COUNT   = miss_count_r;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Self-checking bench for branch_predictor_table: a 2-bit/16-bit instance for
// the main behaviour and a 1-bit/4-bit instance for the parameter sweep.
module tb_branch_predictor_table;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic init_a = 1'b0;
  logic init_b = 1'b0;

  branch_predictor_table_if #(.INDEX_BITS(3), .STAT_BITS(16)) bus_a ();
  branch_predictor_table_if #(.INDEX_BITS(3), .STAT_BITS(4))  bus_b ();

  branch_predictor_table #(.INDEX_BITS(3), .CTR_BITS(2), .STAT_BITS(16)) dut_a (
    .CLOCK(clk), .INIT(init_a), .bus(bus_a)
  );
  branch_predictor_table #(.INDEX_BITS(3), .CTR_BITS(1), .STAT_BITS(4)) dut_b (
    .CLOCK(clk), .INIT(init_b), .bus(bus_b)
  );

  typedef struct {
    logic        init;
    logic        uv;
    logic [2:0]  ua;
    logic        oc;
    logic        pr;
    logic [2:0]  la;
    logic        chk_p;
    logic        exp_p;
    logic        exp_miss;
    logic [2:0]  exp_aw;
    logic [15:0] exp_br;
    logic [15:0] exp_mc;
  } vec_t;

  typedef struct {
    int          sel;
    logic        miss;
    logic [2:0]  aw;
    logic [15:0] br;
    logic [15:0] mc;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vt[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(
    input logic init, input logic uv, input logic [2:0] ua, input logic oc,
    input logic pr, input logic [2:0] la, input logic chk_p, input logic exp_p,
    input logic exp_miss, input logic [2:0] exp_aw, input int exp_br, input int exp_mc
  );
    vec_t v;
    v.init = init; v.uv = uv; v.ua = ua; v.oc = oc; v.pr = pr; v.la = la;
    v.chk_p = chk_p; v.exp_p = exp_p; v.exp_miss = exp_miss; v.exp_aw = exp_aw;
    v.exp_br = exp_br[15:0]; v.exp_mc = exp_mc[15:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Pop the oldest expectation and compare it with the registered outputs.
  task automatic pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      e = sb_q.pop_front();
      if (e.sel == 0) begin
        chk("a_miss",   {15'd0, bus_a.MISS},   {15'd0, e.miss});
        chk("a_addr_w", {13'd0, bus_a.ADDR_W}, {13'd0, e.aw});
        chk("a_branch_count", bus_a.BRANCH_COUNT, e.br);
        chk("a_miss_count",   bus_a.MISS_COUNT,   e.mc);
      end else begin
        chk("b_miss",   {15'd0, bus_b.MISS},   {15'd0, e.miss});
        chk("b_addr_w", {13'd0, bus_b.ADDR_W}, {13'd0, e.aw});
        chk("b_branch_count", {12'd0, bus_b.BRANCH_COUNT}, e.br);
        chk("b_miss_count",   {12'd0, bus_b.MISS_COUNT},   e.mc);
      end
    end
  endtask

  // Called 1 time unit after a rising edge: drive, check lookup, clock, check registers.
  task automatic apply(input int sel, input vec_t v);
    sb_t  e;
    logic got_p;
    if (sel == 0) begin
      init_a = v.init;
      bus_a.UPDATE_VALID = v.uv; bus_a.UPDATE_ADDR = v.ua;
      bus_a.OUTCOME = v.oc; bus_a.PREDICTION = v.pr; bus_a.LOOKUP_ADDR = v.la;
    end else begin
      init_b = v.init;
      bus_b.UPDATE_VALID = v.uv; bus_b.UPDATE_ADDR = v.ua;
      bus_b.OUTCOME = v.oc; bus_b.PREDICTION = v.pr; bus_b.LOOKUP_ADDR = v.la;
    end
    #1;
    got_p = (sel == 0) ? bus_a.PREDICT : bus_b.PREDICT;
    if (v.chk_p) chk(sel == 0 ? "a_predict" : "b_predict", {15'd0, got_p}, {15'd0, v.exp_p});
    e.sel = sel; e.miss = v.exp_miss; e.aw = v.exp_aw; e.br = v.exp_br; e.mc = v.exp_mc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
    if (sel == 0) begin
      init_a = 1'b0; bus_a.UPDATE_VALID = 1'b0;
    end else begin
      init_b = 1'b0; bus_b.UPDATE_VALID = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic       mdl [8];
    logic [2:0] addr;
    logic       oc;
    int         n;

    bus_a.UPDATE_VALID = 1'b0; bus_a.UPDATE_ADDR = 3'd0; bus_a.OUTCOME = 1'b0;
    bus_a.PREDICTION = 1'b0; bus_a.LOOKUP_ADDR = 3'd0;
    bus_b.UPDATE_VALID = 1'b0; bus_b.UPDATE_ADDR = 3'd0; bus_b.OUTCOME = 1'b0;
    bus_b.PREDICTION = 1'b0; bus_b.LOOKUP_ADDR = 3'd0;

    // Vector table for the 2-bit instance; counts are cumulative since reset.
    vt.push_back(mk(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0));
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'(i), 1'b1, 1'b0, 1'b0, 3'd0, 0, 0));
    // Train addr 5 up: 01->10->11->11.
    vt.push_back(mk(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 3'd5, 1, 1));
    vt.push_back(mk(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 1'b1, 3'd5, 2, 2));
    vt.push_back(mk(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 1'b1, 3'd5, 3, 3));
    vt.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 3'd5, 3, 3));
    // Train down: 11->10->01->00->00.
    vt.push_back(mk(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 3'd5, 4, 4));
    vt.push_back(mk(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 3'd5, 5, 5));
    vt.push_back(mk(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 3'd5, 6, 6));
    vt.push_back(mk(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 3'd5, 7, 7));
    vt.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 3'd5, 7, 7));
    // Miss timing on addr 3, then idle, then a hit.
    vt.push_back(mk(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 3'd3, 8, 8));
    vt.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 3'd3, 8, 8));
    vt.push_back(mk(1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd3, 9, 8));
    // Same-cycle lookup/update on addr 2: no forwarding.
    vt.push_back(mk(1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd2, 10, 8));
    vt.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 3'd2, 10, 8));

    @(posedge clk);
    #1;
    apply(1, mk(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0));
    foreach (vt[i]) apply(0, vt[i]);

    // INIT priority: train addr 5 from 00 to 11, then INIT with a mispredicted update.
    apply(0, mk(1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 3'd5, 11, 8));
    apply(0, mk(1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 3'd5, 12, 8));
    apply(0, mk(1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 3'd5, 13, 8));
    apply(0, mk(1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 3'd0, 0, 0));
    apply(0, mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0, 0, 0));
    apply(0, mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0, 0, 0));
    // First update after INIT starts from WNT.
    apply(0, mk(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 3'd5, 1, 1));
    apply(0, mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 3'd5, 1, 1));

    // 1-bit sweep: last-outcome predictor, 4-bit counters saturate at 15.
    for (int i = 0; i < 8; i++) mdl[i] = 1'b0;
    addr = 3'd0;
    for (int i = 0; i < 20; i++) begin
      addr = 3'($urandom_range(7, 0));
      oc   = 1'($urandom_range(1, 0));
      n    = (i + 1 > 15) ? 15 : i + 1;
      apply(1, mk(1'b0, 1'b1, addr, oc, ~oc, addr, 1'b1, mdl[addr], 1'b1, addr, n, n));
      mdl[addr] = oc;
    end
    for (int i = 0; i < 8; i++)
      apply(1, mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'(i), 1'b1, mdl[i], 1'b0, addr, 15, 15));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
